// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES encryption round controller. Owns the 128-bit cipher state
// and steps through one AES round per clock. The S-box/ShiftRows, MixColumns
// and key schedule are external combinational blocks. This module only
// sequences them and does the AddRoundKey XORs.
//
// Sequence for one block:
//   IDLE  : accept plaintext, state <= pt ^ key[0]
//   ROUND : rounds 1..NR-1 use the MixColumns result, and round NR bypasses
//           MixColumns (final AES round)
//   DONE  : ciphertext presented until downstream takes it
//
// Optional feature (compile-time macro AES_SEQ_BACK2BACK_EN):
//   defined   : DONE can hand off its ciphertext and load the next plaintext
//               in the same cycle. Sustained rate is one block per NR+1 cycles.
//   undefined : a new block is only accepted in IDLE. Sustained rate is one
//               block per NR+2 cycles.
//
// Parameters
//   NR      number of rounds (10/12/14 for AES-128/192/256)
//   KIDX_W  width of the round-key index (must be able to hold NR)
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   inValid_i        plaintext valid
//   inReady_o        plaintext accepted this cycle when high together with inValid_i
//   inData_i         plaintext, byte 0 at [127:120]
//   roundKeyIdx_o    round-key index requested this cycle (0..NR)
//   roundKey_i       round key for roundKeyIdx_o, same cycle
//   subInState_o     state to SubBytes+ShiftRows (always the state register)
//   subOutState_i    SubBytes+ShiftRows result
//   mixInState_o     SubBytes+ShiftRows result forwarded to MixColumns
//   mixOutState_i    MixColumns result
//   outValid_o       ciphertext valid, held until accepted
//   outReady_i       downstream accepts ciphertext
//   outData_o        ciphertext (the state register)
//   dbgState_o       FSM state (0 IDLE, 1 ROUND, 2 DONE)
//   dbgRoundCnt_o    current round counter
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. A valid source keeps its data stable until
// that edge. outValid_o does not depend on outReady_i.
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR     = 14,
    parameter int KIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inValid_i,
    output logic              inReady_o,
    input  logic [127:0]      inData_i,
    output logic [KIDX_W-1:0] roundKeyIdx_o,
    input  logic [127:0]      roundKey_i,
    output logic [127:0]      subInState_o,
    input  logic [127:0]      subOutState_i,
    output logic [127:0]      mixInState_o,
    input  logic [127:0]      mixOutState_i,
    output logic              outValid_o,
    input  logic              outReady_i,
    output logic [127:0]      outData_o,
    output logic [1:0]        dbgState_o,
    output logic [KIDX_W-1:0] dbgRoundCnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

    state_e              state_q, state_d;
    logic [KIDX_W-1:0]   round_cnt_q, round_cnt_d;
    logic [127:0]        state_reg_q, state_reg_d;

    logic                in_ready;
    logic                out_valid;
    logic                load;
    logic [KIDX_W-1:0]   key_idx;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            round_cnt_q <= '0;
            state_reg_q <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            state_reg_q <= state_reg_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        state_reg_d = state_reg_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        load        = 1'b0;
        key_idx     = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                load     = inValid_i;
            end

            ST_ROUND: begin
                key_idx = round_cnt_q;
                if (round_cnt_q < NR_K) begin
                    state_reg_d = mixOutState_i ^ roundKey_i;
                    round_cnt_d = round_cnt_q + ONE_K;
                end else begin
                    // Final round: the MixColumns result is skipped.
                    state_reg_d = subOutState_i ^ roundKey_i;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
`ifdef AES_SEQ_BACK2BACK_EN
                // A new block can only enter when the current ciphertext
                // leaves, because both share the state register.
                in_ready = outReady_i;
                if (outReady_i) begin
                    if (inValid_i) begin
                        load = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        round_cnt_d = '0;
                    end
                end
`else
                if (outReady_i) begin
                    state_d     = ST_IDLE;
                    round_cnt_d = '0;
                end
`endif
            end

            default: begin
                state_d     = ST_IDLE;
                round_cnt_d = '0;
            end
        endcase

        // Initial AddRoundKey. roundKeyIdx_o is 0 in every state that can load.
        if (load) begin
            state_reg_d = inData_i ^ roundKey_i;
            round_cnt_d = ONE_K;
            state_d     = ST_ROUND;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // inReady_o is held low during the reset cycle so that nothing looks accepted.
    assign inReady_o     = in_ready & ~rst_i;
    assign outValid_o    = out_valid;
    assign roundKeyIdx_o = key_idx;
    assign subInState_o  = state_reg_q;
    assign mixInState_o  = subOutState_i;
    assign outData_o     = state_reg_q;
    assign dbgState_o    = state_q;
    assign dbgRoundCnt_o = round_cnt_q;

endmodule
